ddr2_mem_sweep_tester: RTL and testbench
========================================

# ddr2_mem_sweep_tester

Parametrised DDR2 pattern tester that drives the RAM wrapper's user port (address / data_in / write_enable / read_request / read_ack / data_out / rdy / rd_data_pres). On each `start` it writes a generated pattern over a programmable address range, reads the range back, compares every word and reports pass, error count and first failing address. It sits between board I/O (switches, LEDs, status) and the RAM wrapper, and shares the wrapper's `systemCLK` domain.

## Interface
- `DATA_W`, 8: user data width.
- `ADDR_W`, 26: RAM word address width.
- `LEN_W`, 16: width of the range-length field.
- `ERR_W`, 16: error counter width (saturating).
- `TIMEOUT`, 1023: maximum cycles in S_RD_WAIT before abort.

- `systemCLK` in 1: clock, from wrapper `clkout`.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request; sampled only in S_IDLE.
- `mode` in 2: 00 constant (`seed`), 01 incrementing, 10 LFSR, 11 walking-ones.
- `base_addr` in ADDR_W: first word address.
- `length` in LEN_W: number of words.
- `seed` in DATA_W: pattern seed.
- `busy` out 1: high from start acceptance until the cycle `done` pulses.
- `done` out 1: one-cycle completion pulse.
- `pass` out 1: 1 when err_count==0 and no timeout; valid from `done`.
- `timeout` out 1: read-wait abort flag.
- `err_count` out ERR_W: mismatches, saturating at all-ones.
- `first_err_addr` out ADDR_W: address of first mismatch.
- `ram_address` out ADDR_W; `ram_data_in` out DATA_W; `ram_write_enable`, `ram_read_request`, `ram_read_ack` out 1.
- `ram_data_out` in DATA_W; `ram_rdy` in 1; `ram_rd_data_pres` in 1.

## Operation
- States: S_IDLE, S_WR, S_RD_REQ, S_RD_WAIT, S_RD_ACK, S_DONE. All transitions except the timeout path are gated by `ram_rdy`; with `ram_rdy`=0 the state and all registers hold, and strobes drop to 0.
- S_IDLE: on `start`, latch mode/base/length/seed, clear err_count/timeout/first_err_addr, index:=0, load generator. `length`==0 goes straight to S_DONE, pass=1, no RAM traffic.
- S_WR: ram_address=base+index (mod 2^ADDR_W), ram_data_in=pattern, ram_write_enable=1 for one cycle; index++, advance generator. After word length-1: index:=0, reload generator, go to S_RD_REQ.
- S_RD_REQ: drive address, ram_read_request=1 for one cycle, go to S_RD_WAIT.
- S_RD_WAIT: wait for `ram_rd_data_pres`; capture `ram_data_out`, compare against pattern, go to S_RD_ACK. Wait counter reaching TIMEOUT sets `timeout` and goes to S_DONE regardless of `ram_rdy`.
- S_RD_ACK: ram_read_ack=1 for one cycle; on mismatch err_count++ (saturating), and first_err_addr is recorded if err_count was 0; index++ and advance generator; last word -> S_DONE, else S_RD_REQ.
- S_DONE: done=1 for one cycle, busy=0, pass updated; return to S_IDLE. Results hold until the next accepted start.
- Patterns (index i): constant = seed; incrementing = seed+i mod 2^DATA_W; LFSR = Galois LFSR stepped per word from seed (seed 0 replaced by 1); walking-ones = rotate-left of 1 by (i mod DATA_W).
- `start` while busy is ignored. Reset mid-operation: FSM to S_IDLE, all strobes 0 on the same edge, and no further RAM commands are issued.

## Timing
- Reset values: all outputs 0 (pass 0, err_count 0, ram_* 0).
- Start acceptance to first write: 1 cycle (S_WR entered on next edge).
- Write rate: 1 word/cycle while ram_rdy=1.
- Read: min 3 cycles/word (REQ, WAIT≥1, ACK).
- Total min latency, start to done: 1 + L + 3L + 1 cycles for read latency 1 and ram_rdy constant.
- Strobes are registered, never combinational from inputs.

## Structure
- Package `ddr2_test_pkg`: state enum, mode constants, LFSR tap function per DATA_W (8: x^8+x^6+x^5+x^4+1; 16: x^16+x^14+x^13+x^11+1; 32: x^32+x^22+x^2+x+1).
- Sub-module `mem_pattern_gen`: load/advance/mode/seed -> pattern; shared by the write and read passes.

## Test plan
- Mode 00, base 0x10, length 1, seed 0xA5, ideal RAM latency 1 -> one write to 0x10 of 0xA5, done at cycle 6, pass=1, err_count=0.
- Mode 01, base 0x3FFFFFE, length 4, seed 0xFE -> addresses 0x3FFFFFE, 0x3FFFFFF, 0x0, 0x1 with data FE, FF, 00, 01; pass=1.
- Mode 10, length 256, RAM stuck bit 3 at 0 from address 0x40 -> err_count equals number of words with bit3=1 in range, first_err_addr is first such address ≥0x40, pass=0.
- Model never asserts rd_data_pres -> timeout=1 after 1023 wait cycles, done pulses, pass=0, no read_ack issued.
- ram_rdy toggled randomly during mode 11, length 16 -> no strobe while rdy=0, data 01,02,…,80 repeating, pass=1.
- Reset asserted in S_RD_WAIT -> all outputs 0 next edge; start while busy ignored; length 0 -> done after 2 cycles, pass=1, no RAM strobes.

Source files
------------

// File: rtl/ddr2_test_pkg.sv
// Shared definitions for the DDR2 sweep tester: FSM encodings, pattern
// mode codes and the Galois LFSR tap masks.
package ddr2_test_pkg;

    typedef logic [2:0] state_t;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR      = 3'd1;
    localparam logic [2:0] S_RD_REQ  = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_RD_ACK  = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [1:0] MODE_CONST = 2'b00;
    localparam logic [1:0] MODE_INCR  = 2'b01;
    localparam logic [1:0] MODE_LFSR  = 2'b10;
    localparam logic [1:0] MODE_WALK  = 2'b11;

    // Right-shifting Galois tap mask: bit k set for each x^(k+1) term.
    // Only 8/16/32 have polynomials here; other widths fall back to the 8-bit one.
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            16:      return 32'h0000_B400;  // x^16+x^14+x^13+x^11+1
            32:      return 32'h8020_0003;  // x^32+x^22+x^2+x+1
            default: return 32'h0000_00B8;  // x^8+x^6+x^5+x^4+1
        endcase
    endfunction

endpackage

// File: rtl/mem_pattern_gen.sv
// Pattern generator shared by the write and read passes. 'pattern' is the
// word for the current index; load restarts the sequence, advance steps it.
module mem_pattern_gen
    import ddr2_test_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              systemCLK,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    output logic [DATA_W-1:0] pattern,
    output logic [DATA_W-1:0] pattern_first,
    output logic [DATA_W-1:0] pattern_step
);

    localparam logic [31:0]       TAPS_FULL = lfsr_taps(DATA_W);
    localparam logic [DATA_W-1:0] TAPS      = TAPS_FULL[DATA_W-1:0];

    // Word 0 of the sequence for the given mode and seed (seed 0 would lock the LFSR).
    always_comb begin
        pattern_first = seed;
        case (mode)
            MODE_LFSR: pattern_first = (seed == '0) ? DATA_W'(1) : seed;
            MODE_WALK: pattern_first = DATA_W'(1);
            default:   pattern_first = seed;
        endcase
    end

    // Word i+1 derived from word i.
    always_comb begin
        pattern_step = pattern;
        case (mode)
            MODE_INCR: pattern_step = pattern + 1'b1;
            MODE_LFSR: pattern_step = (pattern >> 1) ^ (pattern[0] ? TAPS : '0);
            MODE_WALK: pattern_step = {pattern[DATA_W-2:0], pattern[DATA_W-1]};
            default:   pattern_step = pattern;
        endcase
    end

    // Current-word register.
    always_ff @(posedge systemCLK) begin
        if (reset) begin
            pattern <= '0;
        end else if (load) begin
            pattern <= pattern_first;
        end else if (advance) begin
            pattern <= pattern_step;
        end
    end

endmodule

// File: rtl/ddr2_mem_sweep_tester.sv
// DDR2 sweep tester: writes a generated pattern over [base, base+length),
// reads it back, and reports pass / error count / first failing address.
//
// Handshake with the RAM wrapper: ram_rdy is the ready. Every FSM step,
// and therefore every command strobe, is taken only on an edge where
// ram_rdy is high; each strobe is a registered one-cycle pulse that is
// high exactly while the FSM sits in the state that issued it. While
// ram_rdy is low all state holds and no new strobe is raised. Read data
// is valid while ram_rd_data_pres is high and is released by ram_read_ack.
module ddr2_mem_sweep_tester
    import ddr2_test_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 26,
    parameter int LEN_W   = 16,
    parameter int ERR_W   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic              systemCLK,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_write_enable,
    output logic              ram_read_request,
    output logic              ram_read_ack,
    input  logic [DATA_W-1:0] ram_data_out,
    input  logic              ram_rdy,
    input  logic              ram_rd_data_pres,
    output logic [2:0]        dbg_state
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_t            state;
    logic [1:0]        mode_q;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [DATA_W-1:0] seed_q;
    logic [LEN_W-1:0]  index;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mismatch_q;

    logic              gen_load;
    logic              gen_advance;
    logic [1:0]        gen_mode;
    logic [DATA_W-1:0] gen_seed;
    logic [DATA_W-1:0] pat;
    logic [DATA_W-1:0] pat_first;
    logic [DATA_W-1:0] pat_step;

    logic [LEN_W-1:0]  next_index;
    logic [ADDR_W-1:0] next_addr;
    logic              last_word;

    assign next_index = index + 1'b1;
    assign next_addr  = base_q + ADDR_W'(next_index);
    assign last_word  = (index == len_q - 1'b1);
    assign dbg_state  = state;

    mem_pattern_gen #(
        .DATA_W (DATA_W)
    ) u_gen (
        .systemCLK     (systemCLK),
        .reset         (reset),
        .load          (gen_load),
        .advance       (gen_advance),
        .mode          (gen_mode),
        .seed          (gen_seed),
        .pattern       (pat),
        .pattern_first (pat_first),
        .pattern_step  (pat_step)
    );

    // Generator control: load from the live inputs on start, reload from the
    // latched copy between passes, step once per word in each pass.
    always_comb begin
        gen_load    = 1'b0;
        gen_advance = 1'b0;
        gen_mode    = mode_q;
        gen_seed    = seed_q;
        if (state == S_IDLE) begin
            gen_mode = mode;
            gen_seed = seed;
        end
        if (ram_rdy) begin
            case (state)
                S_IDLE:   gen_load = start;
                S_WR: begin
                    gen_load    = last_word;
                    gen_advance = !last_word;
                end
                S_RD_ACK: gen_advance = 1'b1;
                default: ;
            endcase
        end
    end

    // Sweep FSM, command strobes and result registers.
    always_ff @(posedge systemCLK) begin
        if (reset) begin
            state            <= S_IDLE;
            mode_q           <= '0;
            base_q           <= '0;
            len_q            <= '0;
            seed_q           <= '0;
            index            <= '0;
            wait_cnt         <= '0;
            mismatch_q       <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            timeout          <= 1'b0;
            err_count        <= '0;
            first_err_addr   <= '0;
            ram_address      <= '0;
            ram_data_in      <= '0;
            ram_write_enable <= 1'b0;
            ram_read_request <= 1'b0;
            ram_read_ack     <= 1'b0;
        end else begin
            ram_write_enable <= 1'b0;
            ram_read_request <= 1'b0;
            ram_read_ack     <= 1'b0;
            done             <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ram_rdy && start) begin
                        mode_q         <= mode;
                        base_q         <= base_addr;
                        len_q          <= length;
                        seed_q         <= seed;
                        index          <= '0;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        timeout        <= 1'b0;
                        pass           <= 1'b0;
                        busy           <= 1'b1;
                        if (length == '0) begin
                            state <= S_DONE;
                        end else begin
                            state            <= S_WR;
                            ram_write_enable <= 1'b1;
                            ram_address      <= base_addr;
                            ram_data_in      <= pat_first;
                        end
                    end
                end
                S_WR: begin
                    if (ram_rdy) begin
                        if (last_word) begin
                            index            <= '0;
                            state            <= S_RD_REQ;
                            ram_read_request <= 1'b1;
                            ram_address      <= base_q;
                        end else begin
                            index            <= next_index;
                            ram_write_enable <= 1'b1;
                            ram_address      <= next_addr;
                            ram_data_in      <= pat_step;
                        end
                    end
                end
                S_RD_REQ: begin
                    if (ram_rdy) begin
                        state    <= S_RD_WAIT;
                        wait_cnt <= '0;
                    end
                end
                S_RD_WAIT: begin
                    // The wait counter runs every cycle so a stalled wrapper still aborts.
                    if (ram_rdy && ram_rd_data_pres) begin
                        mismatch_q   <= (ram_data_out != pat);
                        state        <= S_RD_ACK;
                        ram_read_ack <= 1'b1;
                    end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                        timeout <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_RD_ACK: begin
                    if (ram_rdy) begin
                        if (mismatch_q) begin
                            if (err_count == '0) begin
                                first_err_addr <= ram_address;
                            end
                            if (err_count != '1) begin
                                err_count <= err_count + 1'b1;
                            end
                        end
                        if (last_word) begin
                            state <= S_DONE;
                        end else begin
                            index            <= next_index;
                            state            <= S_RD_REQ;
                            ram_read_request <= 1'b1;
                            ram_address      <= next_addr;
                        end
                    end
                end
                S_DONE: begin
                    if (ram_rdy) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        pass  <= (err_count == '0) && !timeout;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr2_mem_sweep_tester.sv
// Bench for ddr2_mem_sweep_tester: behavioural RAM wrapper with optional
// stuck-bit and no-response faults, random ram_rdy, and a write scoreboard.
module tb_ddr2_mem_sweep_tester;
    import ddr2_test_pkg::*;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 26;
    localparam int LEN_W   = 16;
    localparam int ERR_W   = 16;
    localparam int TIMEOUT = 1023;

    logic              systemCLK;
    logic              reset;
    logic              start;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  length;
    logic [DATA_W-1:0] seed;
    logic              busy, done, pass, timeout;
    logic [ERR_W-1:0]  err_count;
    logic [ADDR_W-1:0] first_err_addr;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data_in;
    logic              ram_write_enable, ram_read_request, ram_read_ack;
    logic [DATA_W-1:0] ram_data_out;
    logic              ram_rdy;
    logic              ram_rd_data_pres;
    logic [2:0]        dbg_state;

    ddr2_mem_sweep_tester #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .LEN_W (LEN_W),
        .ERR_W (ERR_W), .TIMEOUT (TIMEOUT)
    ) dut (
        .systemCLK        (systemCLK),
        .reset            (reset),
        .start            (start),
        .mode             (mode),
        .base_addr        (base_addr),
        .length           (length),
        .seed             (seed),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .timeout          (timeout),
        .err_count        (err_count),
        .first_err_addr   (first_err_addr),
        .ram_address      (ram_address),
        .ram_data_in      (ram_data_in),
        .ram_write_enable (ram_write_enable),
        .ram_read_request (ram_read_request),
        .ram_read_ack     (ram_read_ack),
        .ram_data_out     (ram_data_out),
        .ram_rdy          (ram_rdy),
        .ram_rd_data_pres (ram_rd_data_pres),
        .dbg_state        (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        systemCLK = 1'b0;
        forever #5 systemCLK = ~systemCLK;
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_wr, n_rr, n_ack;
    bit stuck, no_resp, rdy_random;
    logic rdy_at_edge;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        return x[0] ? ((x >> 1) ^ 8'hB8) : (x >> 1);
    endfunction

    always @(posedge systemCLK) begin
        rdy_at_edge = ram_rdy;
        cyc++;
    end

    // ---------------- RAM model + write scoreboard ----------------
    always @(negedge systemCLK) begin
        logic [ADDR_W+DATA_W-1:0] e;
        logic [DATA_W-1:0] d;
        if (reset) begin
            ram_rd_data_pres = 1'b0;
        end else begin
            if (ram_write_enable || ram_read_request || ram_read_ack)
                check("strobe_rdy", rdy_at_edge, 1);
            if (ram_write_enable) begin
                n_wr++;
                if (exp_q.size() == 0) begin
                    check("wr_extra", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", ram_address, e[ADDR_W+DATA_W-1:DATA_W]);
                    check("wr_data", ram_data_in, e[DATA_W-1:0]);
                end
                mem[ram_address] = ram_data_in;
            end
            if (ram_read_ack) begin
                n_ack++;
                ram_rd_data_pres = 1'b0;
            end
            if (ram_read_request) begin
                n_rr++;
                if (!no_resp) begin
                    d = mem.exists(ram_address) ? mem[ram_address] : '0;
                    if (stuck && ram_address >= 26'h40) d[3] = 1'b0;
                    ram_data_out     = d;
                    ram_rd_data_pres = 1'b1;
                end
            end
        end
        ram_rdy = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ---------------- driver ----------------
    task automatic run_test(input logic [1:0] m, input logic [ADDR_W-1:0] b,
                            input logic [LEN_W-1:0] l, input logic [7:0] s,
                            input bit stuck_in, input bit nores_in, input bit rnd,
                            input bit poke, input int exp_lat);
        logic [7:0] p, lf;
        logic [ADDR_W-1:0] a, e_first;
        int e_err, t0;
        bit e_to;
        stuck   = stuck_in;
        no_resp = nores_in;
        lf      = (s == 8'h00) ? 8'h01 : s;
        e_err   = 0;
        e_first = '0;
        for (int i = 0; i < int'(l); i++) begin
            a = b + ADDR_W'(i);
            case (m)
                2'b00:   p = s;
                2'b01:   p = s + 8'(i);
                2'b10:   p = lf;
                default: p = 8'(1) << (i % 8);
            endcase
            exp_q.push_back({a, p});
            if (stuck_in && a >= 26'h40 && p[3]) begin
                if (e_err == 0) e_first = a;
                e_err++;
            end
            lf = lfsr_next(lf);
        end
        e_to  = nores_in && (l != 0);
        n_wr  = 0;
        n_rr  = 0;
        n_ack = 0;
        @(negedge systemCLK);
        mode = m; base_addr = b; length = l; seed = s; start = 1'b1;
        t0 = cyc;
        @(negedge systemCLK);
        start = 1'b0;
        rdy_random = rnd;
        if (poke) begin
            repeat (5) @(negedge systemCLK);
            mode = 2'b00; base_addr = 26'h200; length = 16'd5; seed = 8'h77; start = 1'b1;
            @(negedge systemCLK);
            start = 1'b0;
        end
        while (done !== 1'b1 && (cyc - t0) < 20000) @(negedge systemCLK);
        check("done_seen", done, 1);
        if (exp_lat >= 0) check("latency", cyc - t0, exp_lat);
        check("pass", pass, (e_err == 0) && !e_to);
        check("err_count", err_count, e_err);
        check("first_err_addr", first_err_addr, e_first);
        check("timeout", timeout, e_to);
        check("busy_at_done", busy, 0);
        check("n_read_ack", n_ack, e_to ? 0 : int'(l));
        check("n_read_req", n_rr, e_to ? 1 : int'(l));
        check("writes_left", exp_q.size(), 0);
        rdy_random = 1'b0;
        @(negedge systemCLK);
        check("done_pulse", done, 0);
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_err"}, err_count, 0);
        check({tag, "_first"}, first_err_addr, 0);
        check({tag, "_addr"}, ram_address, 0);
        check({tag, "_din"}, ram_data_in, 0);
        check({tag, "_we"}, ram_write_enable, 0);
        check({tag, "_rreq"}, ram_read_request, 0);
        check({tag, "_rack"}, ram_read_ack, 0);
        check({tag, "_state"}, dbg_state, S_IDLE);
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; mode = '0; base_addr = '0; length = '0; seed = '0;
        ram_rdy = 1'b1; ram_data_out = '0; ram_rd_data_pres = 1'b0;
        stuck = 1'b0; no_resp = 1'b0; rdy_random = 1'b0; rdy_at_edge = 1'b1;
        repeat (3) @(negedge systemCLK);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge systemCLK);

        // constant, single word
        run_test(2'b00, 26'h10, 16'd1, 8'hA5, 0, 0, 0, 0, 6);
        // incrementing across the address wrap
        run_test(2'b01, 26'h3FFFFFE, 16'd4, 8'hFE, 0, 0, 0, 0, 18);
        // LFSR over 256 words with bit 3 stuck low from 0x40
        run_test(2'b10, 26'h0, 16'd256, 8'h5A, 1, 0, 0, 0, 1 + 256 + 3 * 256 + 1);
        // RAM never answers
        run_test(2'b00, 26'h20, 16'd2, 8'h3C, 0, 1, 0, 0, 1 + 2 + 1 + TIMEOUT + 1);
        // walking ones with random ram_rdy and a start while busy
        run_test(2'b11, 26'h1000, 16'd16, 8'h00, 0, 0, 1, 1, -1);
        // zero length
        run_test(2'b01, 26'h55, 16'd0, 8'h12, 0, 0, 0, 0, 2);
        check("len0_strobes", n_wr + n_rr + n_ack, 0);

        // reset while waiting for read data
        no_resp = 1'b1;
        @(negedge systemCLK);
        mode = 2'b00; base_addr = 26'h100; length = 16'd3; seed = 8'h33; start = 1'b1;
        exp_q.push_back({26'h100, 8'h33});
        exp_q.push_back({26'h101, 8'h33});
        exp_q.push_back({26'h102, 8'h33});
        @(negedge systemCLK);
        start = 1'b0;
        n = 0;
        while (dbg_state !== S_RD_WAIT && n < 50) begin
            @(negedge systemCLK);
            n++;
        end
        check("reach_rd_wait", dbg_state, S_RD_WAIT);
        reset = 1'b1;
        @(negedge systemCLK);
        check_all_zero("midreset");
        reset = 1'b0;
        no_resp = 1'b0;
        n_wr = 0; n_rr = 0; n_ack = 0;
        repeat (30) @(negedge systemCLK);
        check("post_reset_strobes", n_wr + n_rr + n_ack, 0);
        check("post_reset_writes_left", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        n_errors++;
        $display("FAIL watchdog: got no end of test, expected finish before 1ms");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
